// File: rtl/regfile_mp.sv
// regfile_mp: flop-based register file with NREAD registered read ports, write-first bypass
// and a per-entry busy scoreboard. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD-1:0]        rd_en,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    busy_any
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              wr_ok;
    logic              rsv_ok;
    logic [ADDR_W-1:0] port_addr [NREAD];
    logic [DATA_W-1:0] port_data [NREAD];
    logic [NREAD-1:0]  port_busy;

`ifdef REGFILE_ZERO_REG_EN
    assign wr_ok  = wr_en  && (wr_addr  != '0);
    assign rsv_ok = rsv_en && (rsv_addr != '0);
`else
    assign wr_ok  = wr_en;
    assign rsv_ok = rsv_en;
`endif

    // Reserve is applied after the write release so it wins on a same-address collision.
    always_comb begin
        busy_next = busy;
        if (wr_ok)
            busy_next[wr_addr] = 1'b0;
        if (rsv_ok)
            busy_next[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_any <= 1'b0;
        end else begin
            busy     <= busy_next;
            busy_any <= |busy_next;
        end
    end

    // With the zero register, entry 0 is never written or reserved, so mem[0] and busy[0]
    // stay at their reset value and the plain lookup already yields zero / not busy.
    always_comb begin
        for (int k = 0; k < NREAD; k++) begin
            port_addr[k] = rd_addr[k*ADDR_W +: ADDR_W];
            if (wr_ok && (wr_addr == port_addr[k])) begin
                port_data[k] = wr_data;
                port_busy[k] = 1'b0;
            end else begin
                port_data[k] = mem[port_addr[k]];
                port_busy[k] = busy[port_addr[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int k = 0; k < NREAD; k++) begin
                if (rd_en[k]) begin
                    rd_data[k*DATA_W +: DATA_W] <= port_data[k];
                    rd_busy[k]                  <= port_busy[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test-plan sequence plus randomized traffic, checked against an
// array-based reference model of the register file and its scoreboard.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 1 << AW;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              busy_any;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy [DEPTH];
    logic [DW-1:0] m_rd_data [NR];
    bit            m_rd_busy [NR];
    bit            m_busy_any;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: one clock edge of the register file, written from the behavioural rules.
    task automatic modelStep(input logic [NR-1:0] ren, input logic [AW-1:0] a [NR],
                             input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic re, input logic [AW-1:0] ra, input logic rstn);
        bit we_eff;
        bit re_eff;
        if (!rstn) begin
            foreach (m_mem[i]) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            foreach (m_rd_data[k]) begin
                m_rd_data[k] = '0;
                m_rd_busy[k] = 1'b0;
            end
            m_busy_any = 1'b0;
            return;
        end
        we_eff = we && !(ZERO && wa == 0);
        re_eff = re && !(ZERO && ra == 0);
        for (int k = 0; k < NR; k++) begin
            if (ren[k]) begin
                if (ZERO && a[k] == 0) begin
                    m_rd_data[k] = '0;
                    m_rd_busy[k] = 1'b0;
                end else if (we && wa == a[k]) begin
                    m_rd_data[k] = wd;
                    m_rd_busy[k] = 1'b0;
                end else begin
                    m_rd_data[k] = m_mem[a[k]];
                    m_rd_busy[k] = m_busy[a[k]];
                end
            end
        end
        if (we_eff) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (re_eff)
            m_busy[ra] = 1'b1;
        m_busy_any = 1'b0;
        foreach (m_busy[i])
            if (m_busy[i]) m_busy_any = 1'b1;
    endtask

    task automatic applyStimulus(input logic [NR-1:0] ren, input logic [AW-1:0] a0,
                                 input logic [AW-1:0] a1, input logic we,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic re, input logic [AW-1:0] ra, input logic rstn);
        logic [AW-1:0] a [NR];
        a[0] = a0;
        a[1] = a1;
        rd_en    = ren;
        rd_addr  = {a1, a0};
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rsv_en   = re;
        rsv_addr = ra;
        rst_n    = rstn;
        @(posedge clk);
        modelStep(ren, a, we, wa, wd, re, ra, rstn);
        #1;
        checkOutput("rd_data0", rd_data[DW-1:0], m_rd_data[0]);
        checkOutput("rd_data1", rd_data[2*DW-1:DW], m_rd_data[1]);
        checkOutput("rd_busy0", {31'b0, rd_busy[0]}, {31'b0, m_rd_busy[0]});
        checkOutput("rd_busy1", {31'b0, rd_busy[1]}, {31'b0, m_rd_busy[1]});
        checkOutput("busy_any", {31'b0, busy_any}, {31'b0, m_busy_any});
    endtask

    function automatic logic [AW-1:0] pickAddr();
        if ($urandom_range(0, 1) == 1)
            return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        logic [NR-1:0] ren;
        logic [AW-1:0] a0;
        logic [DW-1:0] zero_read_exp;

        // Reset held two cycles with conflicting activity, then read address 7.
        applyStimulus(2'b11, 5'd3, 5'd4, 1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd6, 1'b0);
        applyStimulus(2'b11, 5'd3, 5'd4, 1'b1, 5'd3, 32'h2222_2222, 1'b1, 5'd6, 1'b0);
        applyStimulus(2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        checkOutput("reset_rd_data0", rd_data[DW-1:0], 32'h0);
        checkOutput("reset_rd_busy0", {31'b0, rd_busy[0]}, 32'h0);
        checkOutput("reset_busy_any", {31'b0, busy_any}, 32'h0);

        // Write then read on both ports.
        applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1);
        applyStimulus(2'b11, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        checkOutput("wr_rd_port0", rd_data[DW-1:0], 32'hDEAD_BEEF);
        checkOutput("wr_rd_port1", rd_data[2*DW-1:DW], 32'hDEAD_BEEF);

        // Same-cycle bypass on port 1; port 0 disabled keeps its old value.
        applyStimulus(2'b10, 5'd9, 5'd9, 1'b1, 5'd9, 32'h1234_5678, 1'b0, 5'd0, 1'b1);
        checkOutput("bypass_port1", rd_data[2*DW-1:DW], 32'h1234_5678);
        checkOutput("bypass_busy1", {31'b0, rd_busy[1]}, 32'h0);
        checkOutput("hold_port0", rd_data[DW-1:0], 32'hDEAD_BEEF);

        // Scoreboard reserve and release.
        applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1);
        checkOutput("rsv_busy_any", {31'b0, busy_any}, 32'h1);
        applyStimulus(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        checkOutput("rsv_rd_busy0", {31'b0, rd_busy[0]}, 32'h1);
        applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b1);
        checkOutput("release_busy_any", {31'b0, busy_any}, 32'h0);
        applyStimulus(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        checkOutput("release_rd_busy0", {31'b0, rd_busy[0]}, 32'h0);
        checkOutput("release_rd_data0", rd_data[DW-1:0], 32'hA5A5_A5A5);

        // Reserve/write collision, then reset with a write pending.
        applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd12, 32'h0C0C_0C0C, 1'b1, 5'd12, 1'b1);
        checkOutput("collide_busy_any", {31'b0, busy_any}, 32'h1);
        applyStimulus(2'b01, 5'd12, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        checkOutput("collide_data", rd_data[DW-1:0], 32'h0C0C_0C0C);
        checkOutput("collide_busy", {31'b0, rd_busy[0]}, 32'h1);
        applyStimulus(2'b01, 5'd12, 5'd0, 1'b1, 5'd12, 32'hFFFF_0000, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b01, 5'd12, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        checkOutput("post_reset_data12", rd_data[DW-1:0], 32'h0);
        checkOutput("post_reset_busy_any", {31'b0, busy_any}, 32'h0);

        // Entry 0 behaviour: hardwired zero or ordinary register depending on the build.
        zero_read_exp = ZERO ? 32'h0 : 32'hFFFF_FFFF;
        applyStimulus(2'b01, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b1);
        checkOutput("zero_same_cycle", rd_data[DW-1:0], zero_read_exp);
        applyStimulus(2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        checkOutput("zero_reread", rd_data[DW-1:0], zero_read_exp);
        applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1);
        checkOutput("zero_rsv_busy_any", {31'b0, busy_any}, ZERO ? 32'h0 : 32'h1);

        // Randomized traffic with occasional resets, biased toward low addresses for collisions.
        for (int n = 0; n < 600; n++) begin
            ren = NR'($urandom_range(0, 3));
            a0  = pickAddr();
            applyStimulus(ren, a0, ($urandom_range(0, 3) == 0) ? a0 : pickAddr(),
                          1'($urandom_range(0, 1)), pickAddr(), $urandom(),
                          ($urandom_range(0, 2) == 0), pickAddr(),
                          ($urandom_range(0, 49) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file with synchronous (registered) reads, same-cycle write-to-read bypass and a per-entry busy scoreboard.
- Sits in the RISC-V decode stage. The issue logic reserves a destination register at issue. Writeback then writes it and releases the reservation.
- Replaces the fixed 32x32, two-read-port register file. Storage is flops; nothing is loaded from a file.

Parameters:
- DATA_W, 32, width of each register entry
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- NREAD, 2, number of read ports (1..4)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- rd_en  input  NREAD  per-port read enable
- rd_addr  input  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NREAD*DATA_W  registered read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy  output  NREAD  registered busy flag of the entry read on port k
- wr_en  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rsv_en  input  1  reserve-entry request
- rsv_addr  input  ADDR_W  entry to reserve
- busy_any  output  1  registered; 1 if any entry is reserved

Behaviour:
- One clock domain. Reset is synchronous, active-low (rst_n), sampled on the rising edge of clk.
- Reset: all entries = 0, all busy bits = 0, rd_data = 0, rd_busy = 0, busy_any = 0.
  - Reset overrides any wr_en, rsv_en or rd_en active in the same cycle. Nothing from that cycle is committed.
  - Reset mid-sequence discards all reservations and pending reads.
- Write: if wr_en=1, entry[wr_addr] <= wr_data at the edge, and busy[wr_addr] is cleared.
- Reserve: if rsv_en=1, busy[rsv_addr] is set at the edge.
  - When rsv_en and wr_en target the same address, reserve wins and the busy bit ends set.
  - Writing an entry that is not busy is legal; its busy bit stays 0.
- Read latency is 1 cycle. For each port k with rd_en[k]=1, at the edge:
  - rd_data[k] <= wr_data if (wr_en && wr_addr==rd_addr[k]), else entry[rd_addr[k]]. This is the write-first bypass.
  - rd_busy[k] <= 0 if the bypass is taken, else busy[rd_addr[k]] as held before the edge.
  - A same-cycle reserve is not visible to a same-cycle read.
- For rd_en[k]=0, rd_data[k] and rd_busy[k] hold their previous values.
- All read ports are independent. Any number of ports may read the same address in the same cycle, with identical results.
- busy_any <= OR of the next-state busy vector. It is registered and updates with the busy bits.
- Address wrap: addresses are exactly ADDR_W bits, so no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: entry 0 is hardwired to zero.
  - Writes to address 0 are ignored.
  - Reserves of address 0 are ignored; busy[0] stays 0.
  - A read of address 0 returns 0 with rd_busy=0, including when wr_en targets address 0 in the same cycle (no bypass).
  - busy_any never reflects entry 0.
  - Entry 0 needs no storage flop.
- Not defined: entry 0 is an ordinary register, identical to all others.

Test Plan:
- Reset then read: rst_n=0 for 2 cycles, release, read addr 7 on port 0 -> rd_data[0]=0x00000000, rd_busy[0]=0, busy_any=0.
- Write then read: write 0xDEADBEEF to addr 3, next cycle read addr 3 on both ports -> both ports return 0xDEADBEEF one cycle later.
- Bypass: write 0x12345678 to addr 9 and read addr 9 on port 1 in the same cycle -> rd_data[1]=0x12345678 and rd_busy[1]=0 after one edge; port 0, reading addr 9 with rd_en[0]=0 in that cycle, holds its prior value.
- Scoreboard: reserve addr 5 -> busy_any=1; next cycle read addr 5 -> rd_busy=1. Write 0xA5A5A5A5 to addr 5 -> busy_any=0; read addr 5 -> rd_busy=0, rd_data=0xA5A5A5A5.
- Reserve/write collision on addr 12 in the same cycle -> entry 12 = new data, busy[12]=1, busy_any=1. Then a sync reset with wr_en=1 to addr 12 asserted in the reset cycle -> entry 12 = 0, busy_any=0.
- With REGFILE_ZERO_REG_EN defined: write 0xFFFFFFFF to addr 0 while reading addr 0 in the same cycle, then read again -> rd_data=0 both times. Reserve addr 0 -> busy_any stays 0.
- Without REGFILE_ZERO_REG_EN: the same stimulus -> the same-cycle read returns 0xFFFFFFFF via bypass, the second read returns 0xFFFFFFFF, and after the reserve busy_any=1.
